// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and defaults for the I2C async FIFO read-port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fifo_rd_arb_pkg;

    // Arbiter FSM: single pops from IDLE, locked multi-pop runs in BURST.
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Requester indices into req/lock/gnt/rvalid vectors.
    localparam int REQ_ENGINE = 0;
    localparam int REQ_REGS   = 1;

    // Default configuration.
    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_MAX_BURST    = 4;
    localparam int DEF_STALL_CYCLES = 16;

endpackage

// File: rtl/fifo_rd_arb_rr_arb2.sv
// Combinational 2-way round-robin picker: one-hot winner among requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; a lone requester always wins, ties go to the one that did not win last.
module rr_arb2
    import fifo_rd_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    // last_i=1 means requester 1 won last time, so requester 0 takes a tie.
    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o[REQ_ENGINE] = last_i;
            gnt_o[REQ_REGS]   = ~last_i;
        end
    end

endmodule

// File: rtl/fifo_rd_arb.sv
// Read-port arbiter/sequencer: round-robin single pops or locked bursts, drives rinc_o. Optional stall timeout: FIFO_RD_ARB_TIMEOUT_EN.
// Latency: gnt_o/rinc_o same cycle as the decision; rdata_o/rvalid_o one cycle after the grant.
// Backpressure: no pop while the FIFO is empty or in reset; a burst owner blocks the other requester.
module fifo_rd_arb
    import fifo_rd_arb_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int MAX_BURST    = DEF_MAX_BURST,
    parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
    input  logic                  rclk_i,
    input  logic                  rrst_ni,
    input  logic [1:0]            req_i,
    input  logic [1:0]            lock_i,
    output logic [1:0]            gnt_o,
    output logic [1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  busy_o,
    output logic                  timeout_o,
    output logic                  rinc_o,
    input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
    input  logic                  rempty_i,
    input  logic                  r_almost_empty_i
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    // A locked burst needs room for at least two pops and a non-zero stall limit.
    if (MAX_BURST < 2 || STALL_CYCLES < 1) begin : g_bad_cfg
        $error("fifo_rd_arb: MAX_BURST must be >= 2 and STALL_CYCLES >= 1");
    end

    state_e                state_q, state_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rvalid_q, rvalid_d;
    logic                  busy_q, busy_d;
    logic [1:0]            arb_gnt;
    logic [1:0]            gnt;
    logic                  win;
    logic                  stall_exit;

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               timeout_q, timeout_d;
`endif

    rr_arb2 u_rr_arb2 (
        .req_i  (req_i),
        .last_i (last_q),
        .gnt_o  (arb_gnt)
    );

    assign win = arb_gnt[REQ_REGS];

    // Next-state, grant decision and registered-output staging.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        gnt        = 2'b00;
        stall_exit = 1'b0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        stall_d    = stall_q;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // Gating with rrst_ni keeps rinc_o low while reset is held.
                if (rrst_ni && !rempty_i) begin
                    gnt = arb_gnt;
                end
                if (|gnt) begin
                    last_d = win;
                    // Only lock in when a second word is already present.
                    if (lock_i[win] && !r_almost_empty_i) begin
                        state_d = BURST;
                        owner_d = win;
                        cnt_d   = CNT_W'(1);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                        stall_d = '0;
`endif
                    end
                end
            end
            BURST: begin
                if (rrst_ni && req_i[owner_q] && !rempty_i) begin
                    gnt[owner_q] = 1'b1;
                end
                if (|gnt) begin
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                    stall_d = '0;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_d == STALL_W'(STALL_CYCLES)) begin
                        stall_exit = 1'b1;
                        timeout_d  = 1'b1;
                    end
`endif
                end
                if (!lock_i[owner_q] || ((|gnt) && cnt_d == CNT_W'(MAX_BURST)) || stall_exit) begin
                    state_d = IDLE;
                    last_d  = owner_q;   // hand first priority to the other requester
                    cnt_d   = '0;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
                    stall_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        rvalid_d = gnt;
        rdata_d  = (|gnt) ? fifo_rdata_i : rdata_q;
        busy_d   = (state_d == BURST);
    end

    // State and registered outputs; reset defaults let requester 0 win first.
    always_ff @(posedge rclk_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 2'b00;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
        end
    end

`ifdef FIFO_RD_ARB_TIMEOUT_EN
    // Stall counter and one-cycle timeout pulse.
    always_ff @(posedge rclk_i or negedge rrst_ni) begin
        if (!rrst_ni) begin
            stall_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            stall_q   <= stall_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign gnt_o    = gnt;
    assign rinc_o   = |gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Self-checking bench for fifo_rd_arb: FIFO model, scripted vector table, scoreboard for popped data.
// Latency: expects data/valid one cycle after each grant.
// Backpressure: FIFO model updates empty/almost-empty one edge after a pop or write.
module tb_fifo_rd_arb;

    localparam int DW = 8;

    logic          rclk_i  = 1'b0;
    logic          rrst_ni = 1'b0;
    logic [1:0]    req_i   = 2'b00;
    logic [1:0]    lock_i  = 2'b00;
    logic [1:0]    gnt_o;
    logic [1:0]    rvalid_o;
    logic [DW-1:0] rdata_o;
    logic          busy_o;
    logic          timeout_o;
    logic          rinc_o;
    logic [DW-1:0] fifo_rdata_i     = '0;
    logic          rempty_i         = 1'b1;
    logic          r_almost_empty_i = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]    vld;
        logic [DW-1:0] dat;
    } sb_t;

    typedef struct {
        logic [1:0]    req;
        logic [1:0]    lock;
        logic          wr;
        logic [DW-1:0] wd;
        logic [1:0]    eg;
        logic          eb;
    } vec_t;

    sb_t           sb_q[$];
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] pend_q[$];
    logic [DW-1:0] wr_order_q[$];
    vec_t          vecs[$];

    fifo_rd_arb dut (
        .rclk_i           (rclk_i),
        .rrst_ni          (rrst_ni),
        .req_i            (req_i),
        .lock_i           (lock_i),
        .gnt_o            (gnt_o),
        .rvalid_o         (rvalid_o),
        .rdata_o          (rdata_o),
        .busy_o           (busy_o),
        .timeout_o        (timeout_o),
        .rinc_o           (rinc_o),
        .fifo_rdata_i     (fifo_rdata_i),
        .rempty_i         (rempty_i),
        .r_almost_empty_i (r_almost_empty_i)
    );

    always #5 rclk_i = ~rclk_i;

    // FIFO model: pop on rinc_o, then accept writes; flags registered.
    always @(posedge rclk_i) begin
        if (rinc_o) begin
            n_tests++;
            if (fifo_q.size() == 0) begin
                n_fail++;
                $display("FAIL fifo_underflow: rinc_o=1 with empty FIFO, required 0");
            end else begin
                void'(fifo_q.pop_front());
            end
        end
        while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
        rempty_i         <= (fifo_q.size() == 0);
        r_almost_empty_i <= (fifo_q.size() <= 1);
        fifo_rdata_i     <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [1:0] req, input logic [1:0] lock, input logic wr,
                       input logic [DW-1:0] wd, input logic [1:0] eg, input logic eb);
        vec_t v;
        v.req = req; v.lock = lock; v.wr = wr; v.wd = wd; v.eg = eg; v.eb = eb;
        vecs.push_back(v);
    endtask

    // Check last cycle's registered data, then this cycle's grant.
    task automatic check_rvalid(input string tag);
        sb_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, " rvalid"}, rvalid_o, e.vld);
            chk({tag, " rdata"}, rdata_o, e.dat);
        end else begin
            chk({tag, " rvalid_idle"}, rvalid_o, 2'b00);
        end
    endtask

    task automatic run_cycle(input string tag, input logic [1:0] req, input logic [1:0] lock,
                             input logic wr, input logic [DW-1:0] wd,
                             input logic [1:0] eg, input logic eb, input logic eto);
        sb_t e;
        @(negedge rclk_i);
        req_i  = req;
        lock_i = lock;
        if (wr) begin
            pend_q.push_back(wd);
            wr_order_q.push_back(wd);
        end
        #1;
        check_rvalid(tag);
        chk({tag, " gnt"}, gnt_o, eg);
        chk({tag, " rinc"}, rinc_o, |eg);
        chk({tag, " busy"}, busy_o, eb);
        chk({tag, " timeout"}, timeout_o, eto);
        if (eg != 2'b00) begin
            e.vld = eg;
            e.dat = (wr_order_q.size() > 0) ? wr_order_q.pop_front() : '0;
            sb_q.push_back(e);
        end
    endtask

    initial begin
        sb_t e;

        // Single pop.
        add(2'b00, 2'b00, 1, 8'hA5, 2'b00, 0);
        add(2'b01, 2'b00, 0, 8'h00, 2'b01, 0);
        // Contention: last winner is 0, so requester 1 leads the alternation.
        add(2'b00, 2'b00, 1, 8'h11, 2'b00, 0);
        add(2'b00, 2'b00, 1, 8'h22, 2'b00, 0);
        add(2'b00, 2'b00, 1, 8'h33, 2'b00, 0);
        add(2'b00, 2'b00, 1, 8'h44, 2'b00, 0);
        add(2'b11, 2'b00, 0, 8'h00, 2'b10, 0);
        add(2'b11, 2'b00, 0, 8'h00, 2'b01, 0);
        add(2'b11, 2'b00, 0, 8'h00, 2'b10, 0);
        add(2'b11, 2'b00, 0, 8'h00, 2'b01, 0);
        add(2'b11, 2'b00, 0, 8'h00, 2'b00, 0);
        // Burst cap: one single pop to 1, then 4 locked pops to 0, then 1 again.
        for (int i = 0; i < 6; i++) add(2'b00, 2'b00, 1, 8'h51 + 8'(i), 2'b00, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b10, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b01, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b01, 1);
        add(2'b11, 2'b01, 0, 8'h00, 2'b01, 1);
        add(2'b11, 2'b01, 0, 8'h00, 2'b01, 1);
        add(2'b11, 2'b01, 0, 8'h00, 2'b10, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b00, 0);
        // Empty for 10 cycles, then one word: exactly one pop, lock refused (almost empty).
        for (int i = 0; i < 10; i++) add(2'b11, 2'b00, 0, 8'h00, 2'b00, 0);
        add(2'b11, 2'b01, 1, 8'h66, 2'b00, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b01, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b00, 0);
        add(2'b11, 2'b01, 0, 8'h00, 2'b00, 0);
        // Owner drops req while locked, other requester blocked, lock drop on a pop.
        add(2'b00, 2'b00, 1, 8'h71, 2'b00, 0);
        add(2'b00, 2'b00, 1, 8'h72, 2'b00, 0);
        add(2'b00, 2'b00, 1, 8'h73, 2'b00, 0);
        add(2'b01, 2'b01, 0, 8'h00, 2'b01, 0);
        add(2'b00, 2'b01, 0, 8'h00, 2'b00, 1);
        add(2'b11, 2'b01, 0, 8'h00, 2'b01, 1);
        add(2'b11, 2'b00, 0, 8'h00, 2'b01, 1);
        add(2'b11, 2'b00, 0, 8'h00, 2'b00, 0);

        // Reset values.
        repeat (3) @(negedge rclk_i);
        #1;
        chk("reset gnt", gnt_o, 2'b00);
        chk("reset rvalid", rvalid_o, 2'b00);
        chk("reset rdata", rdata_o, 8'h00);
        chk("reset rinc", rinc_o, 1'b0);
        chk("reset busy", busy_o, 1'b0);
        chk("reset timeout", timeout_o, 1'b0);
        @(negedge rclk_i);
        rrst_ni = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            run_cycle($sformatf("v%0d", i), vecs[i].req, vecs[i].lock, vecs[i].wr,
                      vecs[i].wd, vecs[i].eg, vecs[i].eb, 1'b0);
        end

        // Requester 1 bursts on 2 words, then the FIFO runs dry with lock held.
        run_cycle("stl_w0", 2'b00, 2'b00, 1, 8'h81, 2'b00, 0, 0);
        run_cycle("stl_w1", 2'b00, 2'b00, 1, 8'h82, 2'b00, 0, 0);
        run_cycle("stl_p0", 2'b10, 2'b10, 0, 8'h00, 2'b10, 0, 0);
        run_cycle("stl_p1", 2'b10, 2'b10, 0, 8'h00, 2'b10, 1, 0);
`ifdef FIFO_RD_ARB_TIMEOUT_EN
        for (int k = 1; k <= 16; k++) run_cycle($sformatf("stall%0d", k), 2'b11, 2'b10, 0, 8'h00, 2'b00, 1, 0);
        run_cycle("timeout_pulse", 2'b11, 2'b10, 0, 8'h00, 2'b00, 0, 1);
        run_cycle("timeout_after", 2'b11, 2'b10, 0, 8'h00, 2'b00, 0, 0);
        run_cycle("timeout_rel", 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0);
`else
        for (int k = 1; k <= 20; k++) run_cycle($sformatf("stall%0d", k), 2'b11, 2'b10, 0, 8'h00, 2'b00, 1, 0);
        run_cycle("unlock", 2'b00, 2'b00, 0, 8'h00, 2'b00, 1, 0);
        run_cycle("unlocked", 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0);
`endif

        // Reset asserted during the second pop of a burst.
        run_cycle("rb_w0", 2'b00, 2'b00, 1, 8'h91, 2'b00, 0, 0);
        run_cycle("rb_w1", 2'b00, 2'b00, 1, 8'h92, 2'b00, 0, 0);
        run_cycle("rb_w2", 2'b00, 2'b00, 1, 8'h93, 2'b00, 0, 0);
        run_cycle("rb_p0", 2'b01, 2'b01, 0, 8'h00, 2'b01, 0, 0);
        @(negedge rclk_i);
        req_i  = 2'b01;
        lock_i = 2'b01;
        #1;
        check_rvalid("rb_p1");
        chk("rb_p1 gnt", gnt_o, 2'b01);
        chk("rb_p1 busy", busy_o, 1'b1);
        rrst_ni = 1'b0;
        #1;
        chk("rb_rst gnt", gnt_o, 2'b00);
        chk("rb_rst rinc", rinc_o, 1'b0);
        chk("rb_rst rvalid", rvalid_o, 2'b00);
        chk("rb_rst rdata", rdata_o, 8'h00);
        chk("rb_rst busy", busy_o, 1'b0);
        chk("rb_rst timeout", timeout_o, 1'b0);
        @(negedge rclk_i);
        req_i = 2'b11;
        #1;
        chk("rb_hold gnt", gnt_o, 2'b00);
        chk("rb_hold rinc", rinc_o, 1'b0);
        @(negedge rclk_i);
        req_i   = 2'b00;
        lock_i  = 2'b00;
        rrst_ni = 1'b1;
        run_cycle("rb_after0", 2'b11, 2'b00, 0, 8'h00, 2'b01, 0, 0);
        run_cycle("rb_after1", 2'b11, 2'b00, 0, 8'h00, 2'b10, 0, 0);
        run_cycle("drain", 2'b00, 2'b00, 0, 8'h00, 2'b00, 0, 0);
        chk("scoreboard drained", sb_q.size(), 0);
        chk("fifo drained", fifo_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
